cla_nibble_sequencer: RTL and testbench

- Multi-cycle controller that runs a DW-bit add/subtract through one shared 4-bit carry-lookahead slice.
- Processes one nibble per cycle and chains the nibble carry-out in a register.
- Latches the result and ALU flags (Z, V, N), then returns them over a valid/ready handshake.
- Sits between the execute-stage issue logic and the single external CLA slice.

---
 rtl/cla_nibble_sequencer.sv | 130 +++++++++++++
 tb/tb_cla_nibble_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_sequencer.sv
// Sequences a DW-bit add/subtract through one external 4-bit CLA slice, one nibble per cycle.
// Optional macro CLA_SEQ_SAT_EN clamps overflowed results to the signed min/max.
module cla_nibble_sequencer #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    input  logic          req_sub,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_sum,
    output logic          rsp_ovfl,
    output logic          rsp_zero,
    output logic          rsp_neg,
    output logic          busy,
    output logic [3:0]    slice_a,
    output logic [3:0]    slice_b,
    output logic          slice_cin,
    input  logic [3:0]    slice_sum
);

    localparam int unsigned NN   = DW / 4;
    localparam int unsigned CntW = $clog2(NN);
    localparam int unsigned IdxW = CntW + 2;
    localparam logic [CntW-1:0] LastCnt = CntW'(NN - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_sum;
    logic            r_carry;
    logic [CntW-1:0] r_cnt;
    logic            r_ovfl;
    logic            r_zero;
    logic            r_neg;

    logic [IdxW-1:0] w_idx;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic            w_cout;
    logic [DW-1:0]   w_final;
    logic            w_ovfl;
    logic [DW-1:0]   w_result;
    logic            w_last;

    always_comb begin
        w_idx   = {r_cnt, 2'b00};
        w_a_nib = r_a[w_idx +: 4];
        w_b_nib = r_b[w_idx +: 4];
        w_last  = (r_cnt == LastCnt);
        // Slice carry-out recovered from the operand MSBs and the sum MSB.
        w_cout  = (w_a_nib[3] & w_b_nib[3]) | ((w_a_nib[3] ^ w_b_nib[3]) & ~slice_sum[3]);
        w_final = r_sum;
        w_final[w_idx +: 4] = slice_sum;
        w_ovfl  = (r_a[DW-1] == r_b[DW-1]) & (slice_sum[3] != r_a[DW-1]);
`ifdef CLA_SEQ_SAT_EN
        if (w_ovfl) begin
            w_result = r_a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            w_result = w_final;
        end
`else
        w_result = w_final;
`endif
    end

    assign req_ready = (r_state == StIdle);
    assign busy      = (r_state == StBusy);
    assign rsp_valid = (r_state == StDone);
    assign rsp_sum   = r_sum;
    assign rsp_ovfl  = r_ovfl;
    assign rsp_zero  = r_zero;
    assign rsp_neg   = r_neg;
    assign slice_a   = busy ? w_a_nib : 4'b0;
    assign slice_b   = busy ? w_b_nib : 4'b0;
    assign slice_cin = busy ? r_carry : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_ovfl  <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_b     <= req_sub ? ~req_b : req_b;
                        r_carry <= req_sub;
                        r_cnt   <= '0;
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_sum   <= w_result;
                        r_ovfl  <= w_ovfl;
                        r_zero  <= (w_result == '0);
                        r_neg   <= w_result[DW-1];
                        r_cnt   <= '0;
                        r_state <= StDone;
                    end else begin
                        r_sum   <= w_final;
                        r_cnt   <= r_cnt + CntW'(1);
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench for cla_nibble_sequencer: arithmetic reference model, per-cycle compare,
// directed literal cases and randomized operations. Honours CLA_SEQ_SAT_EN if defined.
module tb_cla_nibble_sequencer;

    localparam int DW = 16;
    localparam int NN = DW / 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic          req_sub = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_sum;
    logic          rsp_ovfl;
    logic          rsp_zero;
    logic          rsp_neg;
    logic          busy;
    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic          slice_cin;
    logic [3:0]    slice_sum;
    logic [4:0]    slice_full;

    cla_nibble_sequencer #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_ovfl  (rsp_ovfl),
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
        .busy      (busy),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_cin (slice_cin),
        .slice_sum (slice_sum)
    );

    // External CLA slice: plain 4-bit adder.
    assign slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};
    assign slice_sum  = slice_full[3:0];

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: protocol phase plus arithmetic result.
    int            m_st = 0;   // 0 idle, 1 busy, 2 done
    int            m_k = 0;
    bit            m_chk_en = 1'b0;
    logic [DW-1:0] m_a = '0, m_b = '0, m_beff = '0, m_sum = '0;
    logic          m_sub = 1'b0, m_v = 1'b0, m_z = 1'b0, m_n = 1'b0;

    task automatic model_finish();
        logic [DW-1:0] raw;
        raw = m_sub ? (m_a - m_b) : (m_a + m_b);
        if (m_sub) m_v = (m_a[DW-1] != m_b[DW-1]) && (raw[DW-1] != m_a[DW-1]);
        else       m_v = (m_a[DW-1] == m_b[DW-1]) && (raw[DW-1] != m_a[DW-1]);
`ifdef CLA_SEQ_SAT_EN
        if (m_v) raw = m_a[DW-1] ? 16'h8000 : 16'h7FFF;
`endif
        m_sum = raw;
        m_z   = (raw == '0);
        m_n   = raw[DW-1];
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_st = 0; m_k = 0; m_sum = '0; m_v = 1'b0; m_z = 1'b0; m_n = 1'b0;
        end else begin
            case (m_st)
                0: if (req_valid) begin
                    m_a = req_a; m_b = req_b; m_sub = req_sub;
                    m_beff = req_sub ? ~req_b : req_b;
                    m_k = 0; m_st = 1;
                end
                1: begin
                    m_k++;
                    if (m_k == NN) begin
                        model_finish();
                        m_st = 2;
                    end
                end
                default: if (rsp_ready) m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_chk_en) begin
            int unsigned mask, lo, e_a, e_b, e_cin;
            check("req_ready", 32'(req_ready), 32'(m_st == 0));
            check("busy", 32'(busy), 32'(m_st == 1));
            check("rsp_valid", 32'(rsp_valid), 32'(m_st == 2));
            if (m_st == 1) begin
                mask  = (32'd1 << (4 * m_k)) - 1;
                lo    = (32'(m_a) & mask) + (32'(m_beff) & mask) + 32'(m_sub);
                e_cin = (lo >> (4 * m_k)) & 1;
                e_a   = (32'(m_a) >> (4 * m_k)) & 32'hF;
                e_b   = (32'(m_beff) >> (4 * m_k)) & 32'hF;
                check("slice_a", 32'(slice_a), e_a);
                check("slice_b", 32'(slice_b), e_b);
                check("slice_cin", 32'(slice_cin), e_cin);
            end else begin
                check("slice_idle", {27'b0, slice_a, slice_cin}, 32'd0);
                check("slice_b_idle", 32'(slice_b), 32'd0);
                check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
                check("rsp_flags", {29'b0, rsp_ovfl, rsp_zero, rsp_neg}, {29'b0, m_v, m_z, m_n});
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!req_ready && g < 20) begin
            @(posedge clk); #1; g++;
        end
        check("wait_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub);
        wait_ready();
        req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = DW'($urandom); req_b = DW'($urandom); req_sub = 1'($urandom);
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub,
                          input int stall, input bit pin, input logic [DW-1:0] e_sum,
                          input logic e_v, input logic e_z, input logic e_n);
        int lat = 0;
        start_op(a, b, sub);
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", 32'(lat), 32'(NN));
        if (pin) begin
            check("lit_sum", 32'(rsp_sum), 32'(e_sum));
            check("lit_flags", {29'b0, rsp_ovfl, rsp_zero, rsp_neg}, {29'b0, e_v, e_z, e_n});
        end
        repeat (stall) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_no_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("return_idle", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] ra, rb;
        rst_n = 1'b0;
        @(posedge clk); #1;
        m_chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_sum", 32'(rsp_sum), 32'd0);

        run_op(16'h1234, 16'h1111, 1'b0, 0, 1'b1, 16'h2345, 1'b0, 1'b0, 1'b0);
        run_op(16'h0FFF, 16'h0001, 1'b0, 0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1, 0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
`ifdef CLA_SEQ_SAT_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 3, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
`else
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b1, 3, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
`endif

        // Reset landing on the BUSY edge with k = 2.
        start_op(16'hABCD, 16'h1357, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_sum", 32'(rsp_sum), 32'd0);
        check("midrst_slice", {27'b0, slice_a, slice_cin}, 32'd0);
        run_op(16'h0100, 16'h0023, 1'b0, 1, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            if (i % 8 == 1) rb = ra;
            if (i % 8 == 3) ra = 16'h8000;
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'b0, '0, 1'b0, 1'b0, 1'b0);
        end

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
